// File: rtl/bin2bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
package bin2bcd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam int BCD_DIGIT_W = 4;
  localparam int ADD3_THRESH = 5;

  // Smallest digit count D such that 10^D exceeds the largest width-bit value.
  function automatic int min_digits(input int width);
    longint unsigned max_v;
    longint unsigned pow10;
    int              d;
    max_v = (64'd1 << width) - 64'd1;
    pow10 = 64'd1;
    d     = 0;
    for (int i = 0; i < 20; i++) begin
      if (pow10 <= max_v) begin
        pow10 = pow10 * 64'd10;
        d++;
      end
    end
    return d;
  endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// Single BCD digit add-3 correction applied before each double-dabble shift.
module bcd_digit_adj
  import bin2bcd_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] digit_i,
  output logic [BCD_DIGIT_W-1:0] digit_o
);

  localparam logic [BCD_DIGIT_W-1:0] THRESH = BCD_DIGIT_W'(ADD3_THRESH);
  localparam logic [BCD_DIGIT_W-1:0] ADD3   = BCD_DIGIT_W'(3);

  assign digit_o = (digit_i >= THRESH) ? digit_i + ADD3 : digit_i;

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter, one bit per cycle.
// Optional two's-complement input support via macro BIN2BCD_SIGNED_EN.
module bin2bcd_seq
  import bin2bcd_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [WIDTH-1:0]            in_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [BCD_DIGIT_W*DIGITS-1:0] out_bcd,
  output logic                        out_neg,
  output logic                        busy
);

  localparam int BCD_W = BCD_DIGIT_W * DIGITS;
  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  // Largest signed magnitude is 2^(WIDTH-1), never a power of ten, so the
  // WIDTH-1 bit digit count already covers it.
`ifdef BIN2BCD_SIGNED_EN
  localparam int REQ_DIGITS = min_digits(WIDTH - 1);
`else
  localparam int REQ_DIGITS = min_digits(WIDTH);
`endif

  generate
    if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
      $error("bin2bcd_seq: WIDTH must be in 2..32");
    end
    if (DIGITS < REQ_DIGITS) begin : g_bad_digits
      $error("bin2bcd_seq: DIGITS too small for WIDTH");
    end
  endgenerate

  state_e           state_q, state_d;
  logic [BCD_W-1:0] acc_q, acc_d, acc_adj;
  logic [WIDTH-1:0] opnd_q, opnd_d, in_mag;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             neg_q, neg_d, in_neg;

`ifdef BIN2BCD_SIGNED_EN
  logic signed [WIDTH-1:0] in_s;
  assign in_s   = $signed(in_data);
  assign in_neg = in_s[WIDTH-1];
  assign in_mag = in_neg ? $unsigned(-in_s) : in_data;
`else
  assign in_neg = 1'b0;
  assign in_mag = in_data;
`endif

  generate
    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
      bcd_digit_adj u_adj (
        .digit_i (acc_q[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
        .digit_o (acc_adj[g*BCD_DIGIT_W +: BCD_DIGIT_W])
      );
    end
  endgenerate

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    opnd_d  = opnd_q;
    cnt_d   = cnt_q;
    neg_d   = neg_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          opnd_d  = in_mag;
          acc_d   = '0;
          cnt_d   = '0;
          neg_d   = in_neg;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        {acc_d, opnd_d} = {acc_adj, opnd_q} << 1;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      opnd_q  <= '0;
      cnt_q   <= '0;
      neg_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      opnd_q  <= opnd_d;
      cnt_q   <= cnt_d;
      neg_q   <= neg_d;
    end
  end

  // In unsigned builds neg_d is always 0, so out_neg stays tied low.
  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign out_bcd   = acc_q;
  assign out_neg   = neg_q;

endmodule

// File: doc/bin2bcd_seq.md
BIN2BCD_SEQ -- requirements
Module: bin2bcd_seq

Interface
REQ-001 Parameter WIDTH, default 8: binary input width (2..32).
REQ-002 Parameter DIGITS, default 3: BCD output digit count.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 in_valid  input  1  in_data holds a value to convert.
REQ-006 in_ready  output  1  converter accepts in_data this cycle.
REQ-007 in_data  input  WIDTH  binary value.
REQ-008 out_valid  output  1  out_bcd/out_neg hold a finished result.
REQ-009 out_ready  input  1  consumer takes the result this cycle.
REQ-010 out_bcd  output  4*DIGITS  packed BCD; digit 0 (ones) in bits [3:0].
REQ-011 out_neg  output  1  result sign; constant 0 when the signed feature is compiled out.
REQ-012 busy  output  1  high whenever the FSM is not in IDLE.

Function
REQ-013 The FSM SHALL have exactly three states: IDLE, SHIFT, DONE.
REQ-014 In IDLE, in_ready SHALL be 1; in SHIFT and DONE, in_ready SHALL be 0.
REQ-015 Transfer in: in_valid & in_ready at an edge SHALL load the operand, clear the BCD accumulator, zero the bit counter and move to SHIFT.
REQ-016 SHIFT iteration: each cycle, every digit >= 5 SHALL get +3, then {accumulator, operand} SHALL shift left by one bit.
REQ-017 SHIFT SHALL last exactly WIDTH cycles; after the WIDTH-th iteration the FSM SHALL enter DONE.
REQ-018 Latency: out_valid SHALL rise after the WIDTH-th edge following the accepting edge.
REQ-019 In DONE, out_valid SHALL be 1, and out_bcd/out_neg SHALL stay stable until out_ready is sampled 1.
REQ-020 DONE & out_ready SHALL return the FSM to IDLE; the next accept is possible no earlier than the following edge.
REQ-021 Sustained throughput SHALL be one conversion per WIDTH+2 cycles.
REQ-022 Digits above the true result SHALL read 0.
REQ-023 in_data values all-zeros and all-ones SHALL convert correctly with no overflow.
REQ-024 in_valid asserted outside IDLE SHALL be ignored, and in_data SHALL not be sampled.
REQ-025 out_bcd SHALL show the accumulator contents in every state; it is meaningful only while out_valid is 1.

Reset
REQ-026 rst_n low SHALL immediately force state IDLE, accumulator 0, operand 0, counter 0 and out_neg 0.
REQ-027 During reset, outputs SHALL be in_ready=1, out_valid=0, busy=0, out_bcd=0.
REQ-028 Reset in SHIFT or DONE SHALL discard the conversion, and no out_valid SHALL follow for it.

Configuration
REQ-029 Macro BIN2BCD_SIGNED_EN defined:
  - in_data is two's complement.
  - Negative inputs are negated before SHIFT, and out_neg is latched 1 on accept.
  - Input -2^(WIDTH-1) SHALL yield magnitude 2^(WIDTH-1).
REQ-030 Macro BIN2BCD_SIGNED_EN undefined: in_data is unsigned and out_neg is tied to 0.

Structure
REQ-031 Package bin2bcd_pkg SHALL hold:
  - the state enum;
  - the constant BCD_DIGIT_W=4;
  - the constant ADD3_THRESH=5;
  - the function min_digits(width), which returns the smallest D with 10^D > 2^width-1.
REQ-032 Elaboration SHALL fail if DIGITS < min_digits(WIDTH); in signed mode, the check uses WIDTH-1 magnitude bits plus one.
REQ-033 Sub-module bcd_digit_adj: combinational single-digit add-3 adjust, instantiated DIGITS times via generate.

Verification
REQ-034 WIDTH=8, DIGITS=3, unsigned: in_data=255 -> out_valid 8 cycles after accept, out_bcd=0x255.
REQ-035 in_data=0 -> out_bcd=0x000; then in_data=100 -> out_bcd=0x100; each takes 10 cycles end to end.
REQ-036 out_ready held 0 for 5 cycles in DONE -> out_bcd and out_valid stable, in_ready=0 throughout.
REQ-037 rst_n pulsed low at SHIFT iteration 4 of 200 -> outputs go to reset values at once, and no out_valid follows.
REQ-038 BIN2BCD_SIGNED_EN, WIDTH=8, DIGITS=3:
  - in_data=0x80 -> out_neg=1, out_bcd=0x128;
  - in_data=0x7F -> out_neg=0, out_bcd=0x127.
REQ-039 WIDTH=16, DIGITS=5: in_data=65535 -> out_bcd=0x65535 after 16 cycles.
